// File: rtl/tdes_round_sequencer.sv
// tdes_round_sequencer: Feistel round sequencer for DES/TDES, owns L/R and drives the key schedule
module tdes_round_sequencer #(
    parameter int NUM_PASSES = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic        decrypt,
    output logic [31:0] f_r,
    input  logic [31:0] f_result,
    output logic [1:0]  key_sel,
    output logic        key_dir,
    output logic        key_load,
    output logic        key_step,
    output logic [1:0]  key_shift,
    output logic [1:0]  pass_idx,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block
);
    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_key   = 2'd1;
    localparam logic [1:0] st_round = 2'd2;
    localparam logic [1:0] st_done  = 2'd3;

    logic [1:0]  state;
    logic [31:0] l, r;
    logic        mode;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= st_idle;
            l         <= '0;
            r         <= '0;
            mode      <= 1'b0;
            pass_idx  <= '0;
            round_idx <= '0;
        end else if (clear) begin
            state     <= st_idle;
            pass_idx  <= '0;
            round_idx <= '0;
        end else begin
            case (state)
                st_idle: if (in_valid) begin
                    {l, r}   <= in_block;
                    mode     <= decrypt;
                    pass_idx <= '0;
                    state    <= st_key;
                end
                st_key: begin
                    round_idx <= '0;
                    state     <= st_round;
                end
                st_round: if (round_idx != 4'd15) begin
                    l         <= r;
                    r         <= l ^ f_result;
                    round_idx <= round_idx + 4'd1;
                end else begin
                    // last round skips the swap so {L,R} already holds {R16,L16}
                    l         <= l ^ f_result;
                    round_idx <= '0;
                    if (pass_idx == 2'(NUM_PASSES - 1)) begin
                        state <= st_done;
                    end else begin
                        pass_idx <= pass_idx + 2'd1;
                        state    <= st_key;
                    end
                end
                default: if (out_ready) begin
                    pass_idx <= '0;
                    state    <= st_idle;
                end
            endcase
        end
    end

    // EDE/DED: key order reverses with mode, direction alternates per pass
    always_comb begin
        in_ready  = state == st_idle;
        key_load  = state == st_key;
        key_step  = state == st_round;
        busy      = key_load || key_step;
        out_valid = state == st_done;
        f_r       = r;
        out_block = {l, r};
        key_dir   = NUM_PASSES == 1 ? mode : mode ^ pass_idx[0];
        key_sel   = NUM_PASSES == 1 ? 2'd0 : mode ? 2'd2 - pass_idx : pass_idx;
        key_shift = !key_step ? 2'd0 :
                    round_idx == 4'd0 ? {1'b0, ~key_dir} :
                    (round_idx == 4'd1 || round_idx == 4'd8 || round_idx == 4'd15) ? 2'd1 : 2'd2;
    end
endmodule

// File: tb/tb_tdes_round_sequencer.sv
// tb_tdes_round_sequencer: bench with DES f-function/key-schedule environment and TDES reference model
module tb_tdes_round_sequencer;
    logic        clk = 1'b0, n_rst = 1'b0, clear = 1'b0, in_valid = 1'b0, decrypt = 1'b0, out_ready = 1'b0;
    logic [63:0] in_block = '0;
    logic [31:0] f_r, f_result;
    logic [1:0]  key_sel, key_shift, pass_idx;
    logic        key_dir, key_load, key_step, busy, out_valid, in_ready;
    logic [3:0]  round_idx;
    logic [63:0] out_block;

    tdes_round_sequencer #(.NUM_PASSES(3)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .decrypt(decrypt), .f_r(f_r), .f_result(f_result),
        .key_sel(key_sel), .key_dir(key_dir), .key_load(key_load), .key_step(key_step),
        .key_shift(key_shift), .pass_idx(pass_idx), .round_idx(round_idx), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
    );

    always #5 clk = ~clk;

    localparam int ip_t [0:63] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int p_t [0:31] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int pc1_t [0:55] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
        7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int pc2_t [0:47] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
        16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int sbox_t [0:511] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};
    localparam int sh_enc [0:15] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int sh_dec [0:15] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic logic [63:0] ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) ip[63-i] = x[64-ip_t[i]];
    endfunction
    function automatic logic [63:0] fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) fp[64-ip_t[i]] = x[63-i];
    endfunction
    function automatic logic [55:0] pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) pc1[55-i] = x[64-pc1_t[i]];
    endfunction
    function automatic logic [47:0] pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) pc2[47-i] = x[56-pc2_t[i]];
    endfunction
    function automatic logic [55:0] rot(input logic [55:0] cd, input logic [1:0] n, input logic dir);
        logic [27:0] c, d;
        c = cd[55:28];
        d = cd[27:0];
        for (int k = 0; k < int'(n); k++) begin
            c = dir ? {c[0], c[27:1]} : {c[26:0], c[27]};
            d = dir ? {d[0], d[27:1]} : {d[26:0], d[27]};
        end
        return {c, d};
    endfunction
    function automatic logic [31:0] ffun(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        for (int j = 0; j < 48; j++) x[47-j] = r[31 - ((4*(j/6) + j%6 + 31) % 32)];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = 4'(sbox_t[b*64 + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1])]);
        end
        for (int i = 0; i < 32; i++) ffun[31-i] = s[32-p_t[i]];
    endfunction
    function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        logic [47:0] sk [16];
        logic [55:0] c;
        logic [63:0] b;
        logic [31:0] l, r, t;
        c = pc1(key);
        for (int i = 0; i < 16; i++) begin
            c = rot(c, 2'(sh_enc[i]), 1'b0);
            sk[i] = pc2(c);
        end
        b = ip(blk);
        l = b[63:32];
        r = b[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ ffun(r, sk[dec ? 15 - i : i]);
            l = t;
        end
        return fp({r, l});
    endfunction
    function automatic logic [63:0] tdes(input logic [63:0] k1, k2, k3, pt, input logic dec);
        return dec ? des(k1, des(k2, des(k3, pt, 1'b1), 1'b0), 1'b1)
                   : des(k3, des(k2, des(k1, pt, 1'b0), 1'b1), 1'b0);
    endfunction

    // key-schedule environment steered only by the sequencer's key_* commands
    logic [63:0] keys [3];
    logic [55:0] cd = '0;
    always @(posedge clk) begin
        if (key_load) cd <= pc1(keys[key_sel]);
        else if (key_step) cd <= rot(cd, key_shift, key_dir);
    end
    assign f_result = ffun(f_r, pc2(rot(cd, key_shift, key_dir)));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       logging = 1'b0;
    int         loads = 0;
    logic [4:0] klog [$];
    always @(negedge clk) begin
        if (logging && key_load) loads <= loads + 1;
        if (logging && key_step) klog.push_back({key_sel, key_dir, key_shift});
    end

    typedef struct {
        logic [63:0] k1, k2, k3, pt;
        logic        dec;
        logic [63:0] exp;
    } vec_t;
    vec_t        vecs [6];
    logic [63:0] sbq [$];
    int          checks = 0, errors = 0, acc = 0;
    localparam logic [63:0] std_key = 64'h133457799BBCDFF1;
    localparam logic [63:0] std_pt  = 64'h0123456789ABCDEF;
    localparam logic [63:0] std_ct  = 64'h85E813540F0AB405;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_key_cmd"}, 64'({key_load, key_step, key_shift}), 64'd0);
        chk({tag, "_idx"}, 64'({pass_idx, round_idx}), 64'd0);
        chk({tag, "_out_block"}, out_block, 64'd0);
        chk({tag, "_f_r"}, 64'(f_r), 64'd0);
    endtask

    task automatic send(input logic [63:0] pt, input logic dec, input logic [63:0] exp);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_block = ip(pt);
        decrypt  = dec;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        acc = cyc;
        sbq.push_back(exp);
        chk("accept_busy", 64'(busy), 64'd1);
    endtask

    task automatic recv(input int hold);
        int n = 0;
        logic [63:0] ob;
        while (!out_valid && n < 100) begin tick(); n++; end
        if (!out_valid) begin
            chk("out_valid_timeout", 64'(out_valid), 64'd1);
            return;
        end
        chk("latency", 64'(cyc - acc), 64'd51);
        ob = out_block;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_block = {$urandom, $urandom};
            tick();
            chk("hold_stable", out_block, ob);
            chk("hold_flags", 64'({in_ready, out_valid, busy}), 64'b010);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sbq.size() == 0) chk("unexpected_output", 64'd0, 64'd1);
        else chk("ct", fp(out_block), sbq.pop_front());
        tick();
        out_ready = 1'b0;
        chk("idle_after", 64'({in_ready, out_valid}), 64'b10);
    endtask

    task automatic wait_round(input logic [1:0] p, input logic [3:0] r);
        int n = 0;
        while (!(key_step && pass_idx == p && round_idx == r) && n < 300) begin tick(); n++; end
        if (!key_step) chk("wait_round_timeout", 64'(key_step), 64'd1);
    endtask

    initial begin
        logic [63:0] pt2, exp2;
        vecs[0] = '{std_key, std_key, std_key, std_pt, 1'b0, std_ct};
        vecs[1] = '{std_key, std_key, std_key, std_ct, 1'b1, std_pt};
        for (int i = 2; i < 6; i++) begin
            vecs[i].k1  = {$urandom, $urandom};
            vecs[i].k2  = {$urandom, $urandom};
            vecs[i].k3  = {$urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom};
            vecs[i].dec = 1'(i % 2);
            vecs[i].exp = tdes(vecs[i].k1, vecs[i].k2, vecs[i].k3, vecs[i].pt, vecs[i].dec);
        end
        #22 n_rst = 1'b1;
        tick();
        chk_reset("reset");

        for (int i = 0; i < 6; i++) begin
            keys[0] = vecs[i].k1;
            keys[1] = vecs[i].k2;
            keys[2] = vecs[i].k3;
            logging = i == 1;
            send(vecs[i].pt, vecs[i].dec, vecs[i].exp);
            recv(i == 3 ? 10 : 0);
            logging = 1'b0;
        end

        chk("key_load_pulses", 64'(loads), 64'd3);
        chk("key_log_len", 64'(klog.size()), 64'd48);
        for (int j = 0; j < 48 && j < klog.size(); j++) begin
            automatic int p = j / 16;
            automatic logic d = ~p[0];
            chk($sformatf("key_log_%0d", j), 64'(klog[j]),
                64'({2'(2 - p), d, 2'(d ? sh_dec[j%16] : sh_enc[j%16])}));
        end

        keys[0] = std_key;
        keys[1] = std_key;
        keys[2] = std_key;
        send(std_pt, 1'b0, std_ct);
        wait_round(2'd1, 4'd7);
        n_rst = 1'b0;
        #1 chk_reset("async_reset");
        sbq.delete();
        repeat (3) tick();
        chk("reset_no_output", 64'(out_valid), 64'd0);
        @(negedge clk) n_rst = 1'b1;
        tick();
        send(std_pt, 1'b0, std_ct);
        recv(0);

        keys[0] = vecs[2].k1;
        keys[1] = vecs[2].k2;
        keys[2] = vecs[2].k3;
        send(vecs[2].pt, 1'b0, tdes(vecs[2].k1, vecs[2].k2, vecs[2].k3, vecs[2].pt, 1'b0));
        wait_round(2'd2, 4'd3);
        pt2  = {$urandom, $urandom};
        exp2 = tdes(vecs[2].k1, vecs[2].k2, vecs[2].k3, pt2, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_block = ip(pt2);
        decrypt  = 1'b0;
        tick();
        clear = 1'b0;
        chk("clear_idle", 64'({in_ready, busy, out_valid}), 64'b100);
        chk("clear_idx", 64'({pass_idx, round_idx}), 64'd0);
        sbq.delete();
        sbq.push_back(exp2);
        tick();
        in_valid = 1'b0;
        acc = cyc;
        chk("accept_after_clear", 64'(busy), 64'd1);
        recv(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
